// File: rtl/i2s_sample_scheduler_pkg.sv
// Shared definitions for the I2S sample scheduler.
// Holds the scheduler state type, channel indices into the two-bit
// per-channel valid/ready vectors, and the push-source selector used by
// the round-robin pointer.
package i2s_sample_scheduler_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SYNC  = 2'd1,
    S_LEFT  = 2'd2,
    S_RIGHT = 2'd3
  } sched_state_e;

  typedef enum logic {
    SRC_A = 1'b0,
    SRC_B = 1'b1
  } src_sel_e;

  localparam int unsigned CH_L = 1;
  localparam int unsigned CH_R = 0;

  // Stereo frame width for a given per-channel sample width.
  function automatic int unsigned frame_width(input int unsigned bit_depth);
    return 2 * bit_depth;
  endfunction

endpackage

// File: rtl/i2s_sample_scheduler_fifo.sv
// sample_frame_fifo: synchronous frame FIFO with flush.
// Ports:
//   sys_clk, sys_reset_n  clock, synchronous active-low reset
//   flush                 empties the FIFO; overrides a concurrent push
//   push, push_data       write one frame (ignored when full)
//   pop, pop_data         read one frame; pop_data shows the head (show-ahead)
//   count, full, empty    registered occupancy status
module sample_frame_fifo #(
  parameter int unsigned WIDTH = 48,
  parameter int unsigned DEPTH = 4
) (
  input  logic                       sys_clk,
  input  logic                       sys_reset_n,
  input  logic                       flush,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           pop_data,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty
);
  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full     = (count == (AW+1)'(DEPTH));
  assign empty    = (count == '0);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge sys_clk) begin
    if (!sys_reset_n || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge sys_clk) begin
    if (sys_reset_n && !flush && do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/i2s_sample_scheduler.sv
// i2s_sample_scheduler: feeds stereo frames to an I2S transmitter.
// Two producers (A = CPU MMIO, B = tone generator) push {left,right} frames
// into a small FIFO under fixed-priority or round-robin arbitration. Rising
// edges of the transmitter's per-slot requests launch a frame on the left
// slot (pop + volume shift, or silence on underrun) and then present the
// right sample on the right slot.
// Ports:
//   sys_clk, sys_reset_n          clock, synchronous active-low reset
//   enable                        run scheduler; 0 = idle, silent outputs
//   arb_mode                      0 = A over B, 1 = round-robin
//   vol_shift                     arithmetic right shift applied at pop
//   flush                         empties the frame FIFO
//   src_a_*, src_b_*              producer valid/ready frame ports
//   pcm_data, pcm_data_valid      sample + per-channel valid ([1]=L, [0]=R)
//   pcm_data_ready                per-channel slot requests ([1]=L, [0]=R)
//   fifo_count                    frames buffered
//   underrun, underrun_clr        sticky underrun flag and its clear
//   underrun_count                saturating underrun counter
//   frame_tick                    pulse per left-slot frame launch
module i2s_sample_scheduler
  import i2s_sample_scheduler_pkg::*;
#(
  parameter int unsigned BIT_DEPTH      = 24,
  parameter int unsigned FIFO_DEPTH     = 4,
  parameter int unsigned UNDERRUN_CNT_W = 16
) (
  input  logic                            sys_clk,
  input  logic                            sys_reset_n,
  input  logic                            enable,
  input  logic                            arb_mode,
  input  logic [$clog2(BIT_DEPTH)-1:0]    vol_shift,
  input  logic                            flush,
  input  logic [2*BIT_DEPTH-1:0]          src_a_data,
  input  logic                            src_a_valid,
  output logic                            src_a_ready,
  input  logic [2*BIT_DEPTH-1:0]          src_b_data,
  input  logic                            src_b_valid,
  output logic                            src_b_ready,
  output logic [BIT_DEPTH-1:0]            pcm_data,
  output logic [1:0]                      pcm_data_valid,
  input  logic [1:0]                      pcm_data_ready,
  output logic [$clog2(FIFO_DEPTH):0]     fifo_count,
  output logic                            underrun,
  input  logic                            underrun_clr,
  output logic [UNDERRUN_CNT_W-1:0]       underrun_count,
  output logic                            frame_tick
);
  localparam int unsigned FW = frame_width(BIT_DEPTH);

  sched_state_e         state;
  sched_state_e         state_nxt;
  src_sel_e             rr_next;
  logic                 grant_a;
  logic                 grant_b;
  logic                 push;
  logic [FW-1:0]        push_data;
  logic                 pop;
  logic [FW-1:0]        pop_data;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic [1:0]           ready_q;
  logic                 req_l;
  logic                 req_r;
  logic                 launch;
  logic [BIT_DEPTH-1:0] pop_l;
  logic [BIT_DEPTH-1:0] pop_r;
  logic [BIT_DEPTH-1:0] launch_l;
  logic [BIT_DEPTH-1:0] launch_r;
  logic [BIT_DEPTH-1:0] cur_r;
  logic [BIT_DEPTH-1:0] pcm_data_nxt;
  logic [1:0]           pcm_valid_nxt;

  // Push arbitration; grants look only at the registered full flag, so a
  // pop in the same cycle never opens a slot for a push.
  always_comb begin
    grant_a = 1'b0;
    grant_b = 1'b0;
    if (sys_reset_n && !flush && !fifo_full) begin
      if (src_a_valid && src_b_valid) begin
        if (arb_mode && (rr_next == SRC_B)) grant_b = 1'b1;
        else                                grant_a = 1'b1;
      end else begin
        grant_a = src_a_valid;
        grant_b = src_b_valid;
      end
    end
  end

  assign src_a_ready = grant_a;
  assign src_b_ready = grant_b;
  assign push        = grant_a || grant_b;
  assign push_data   = grant_b ? src_b_data : src_a_data;

  always_ff @(posedge sys_clk) begin
    if (!sys_reset_n) begin
      rr_next <= SRC_A;
    end else if (arb_mode && src_a_valid && src_b_valid && push) begin
      rr_next <= grant_a ? SRC_B : SRC_A;
    end
  end

  sample_frame_fifo #(
    .WIDTH (FW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .sys_clk     (sys_clk),
    .sys_reset_n (sys_reset_n),
    .flush       (flush),
    .push        (push),
    .push_data   (push_data),
    .pop         (pop),
    .pop_data    (pop_data),
    .count       (fifo_count),
    .full        (fifo_full),
    .empty       (fifo_empty)
  );

  // Slot requests act on their rising edge only.
  always_ff @(posedge sys_clk) begin
    if (!sys_reset_n) ready_q <= 2'b00;
    else              ready_q <= pcm_data_ready;
  end

  assign req_l = pcm_data_ready[CH_L] && !ready_q[CH_L];
  assign req_r = pcm_data_ready[CH_R] && !ready_q[CH_R];

  assign pop_l    = $signed(pop_data[FW-1:BIT_DEPTH]) >>> vol_shift;
  assign pop_r    = $signed(pop_data[BIT_DEPTH-1:0]) >>> vol_shift;
  assign pop      = launch && !fifo_empty;
  assign launch_l = fifo_empty ? '0 : pop_l;
  assign launch_r = fifo_empty ? '0 : pop_r;

  always_ff @(posedge sys_clk) begin
    if (!sys_reset_n) state <= S_IDLE;
    else              state <= state_nxt;
  end

  // Next state and next registered outputs; outputs hold by default so the
  // current slot keeps its sample until the next request edge.
  always_comb begin
    state_nxt     = state;
    launch        = 1'b0;
    pcm_data_nxt  = pcm_data;
    pcm_valid_nxt = pcm_data_valid;
    if (!enable) begin
      state_nxt     = S_IDLE;
      pcm_data_nxt  = '0;
      pcm_valid_nxt = 2'b00;
    end else begin
      case (state)
        S_IDLE: begin
          state_nxt     = S_SYNC;
          pcm_data_nxt  = '0;
          pcm_valid_nxt = 2'b00;
        end
        S_SYNC: begin
          pcm_data_nxt  = '0;
          pcm_valid_nxt = 2'b00;
          if (req_l) launch = 1'b1;
        end
        S_LEFT: begin
          if (req_r) begin
            state_nxt     = S_RIGHT;
            pcm_data_nxt  = cur_r;
            pcm_valid_nxt = 2'b01;
          end
        end
        S_RIGHT: begin
          if (req_l) launch = 1'b1;
        end
        default: begin
          state_nxt     = S_IDLE;
          pcm_data_nxt  = '0;
          pcm_valid_nxt = 2'b00;
        end
      endcase
      if (launch) begin
        state_nxt     = S_LEFT;
        pcm_data_nxt  = launch_l;
        pcm_valid_nxt = 2'b10;
      end
    end
  end

  always_ff @(posedge sys_clk) begin
    if (!sys_reset_n) begin
      pcm_data       <= '0;
      pcm_data_valid <= 2'b00;
      frame_tick     <= 1'b0;
      cur_r          <= '0;
    end else begin
      pcm_data       <= pcm_data_nxt;
      pcm_data_valid <= pcm_valid_nxt;
      frame_tick     <= launch;
      if (launch) cur_r <= launch_r;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (!sys_reset_n || underrun_clr) begin
      underrun       <= 1'b0;
      underrun_count <= '0;
    end else if (launch && fifo_empty) begin
      underrun <= 1'b1;
      if (underrun_count != '1) underrun_count <= underrun_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_i2s_sample_scheduler.sv
module tb_i2s_sample_scheduler;
  localparam int unsigned BD = 24;

  logic          sys_clk;
  logic          sys_reset_n;
  logic          enable;
  logic          arb_mode;
  logic [4:0]    vol_shift;
  logic          flush;
  logic [47:0]   src_a_data;
  logic          src_a_valid;
  logic          src_a_ready;
  logic [47:0]   src_b_data;
  logic          src_b_valid;
  logic          src_b_ready;
  logic [23:0]   pcm_data;
  logic [1:0]    pcm_data_valid;
  logic [1:0]    pcm_data_ready;
  logic [2:0]    fifo_count;
  logic          underrun;
  logic          underrun_clr;
  logic [15:0]   underrun_count;
  logic          frame_tick;

  i2s_sample_scheduler #(
    .BIT_DEPTH      (BD),
    .FIFO_DEPTH     (4),
    .UNDERRUN_CNT_W (16)
  ) dut (
    .sys_clk        (sys_clk),
    .sys_reset_n    (sys_reset_n),
    .enable         (enable),
    .arb_mode       (arb_mode),
    .vol_shift      (vol_shift),
    .flush          (flush),
    .src_a_data     (src_a_data),
    .src_a_valid    (src_a_valid),
    .src_a_ready    (src_a_ready),
    .src_b_data     (src_b_data),
    .src_b_valid    (src_b_valid),
    .src_b_ready    (src_b_ready),
    .pcm_data       (pcm_data),
    .pcm_data_valid (pcm_data_valid),
    .pcm_data_ready (pcm_data_ready),
    .fifo_count     (fifo_count),
    .underrun       (underrun),
    .underrun_clr   (underrun_clr),
    .underrun_count (underrun_count),
    .frame_tick     (frame_tick)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  int n_tests;
  int n_fail;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: frame queue plus slot bookkeeping.
  logic [47:0] mq[$];
  bit          m_rr_b;
  logic [1:0]  m_prev;
  bit          m_run;
  bit          m_synced;
  bit          m_on_left;
  logic [23:0] m_cur_r;
  logic [23:0] e_data;
  logic [1:0]  e_valid;
  bit          e_tick;
  bit          e_unr;
  logic [15:0] e_cnt;
  bit          e_ga;
  bit          e_gb;
  bit          obs_a;
  bit          obs_b;

  // Arithmetic right shift == floor division by 2^sh.
  function automatic logic [23:0] vol(input logic [23:0] s, input logic [4:0] sh);
    int v;
    int d;
    logic [31:0] r;
    v = $signed(s);
    d = 1 << sh;
    if (v >= 0) v = v / d;
    else        v = -((-v + d - 1) / d);
    r = v;
    return r[23:0];
  endfunction

  task automatic model_step();
    bit rl;
    bit rr;
    bit launch;
    logic [47:0] f;
    e_ga = 0;
    e_gb = 0;
    if (sys_reset_n && !flush && mq.size() < 4) begin
      if (src_a_valid && src_b_valid) begin
        if (arb_mode && m_rr_b) e_gb = 1;
        else                    e_ga = 1;
        if (arb_mode) m_rr_b = e_ga;
      end else begin
        e_ga = src_a_valid;
        e_gb = src_b_valid;
      end
    end
    if (!sys_reset_n) begin
      mq.delete();
      m_rr_b = 0; m_prev = 2'b00; m_run = 0; m_synced = 0; m_on_left = 0;
      m_cur_r = '0; e_data = '0; e_valid = 2'b00; e_tick = 0; e_unr = 0; e_cnt = '0;
      return;
    end
    rl = pcm_data_ready[1] && !m_prev[1];
    rr = pcm_data_ready[0] && !m_prev[0];
    m_prev = pcm_data_ready;
    launch = 0;
    e_tick = 0;
    if (!enable) begin
      m_run = 0; e_data = '0; e_valid = 2'b00;
    end else if (!m_run) begin
      m_run = 1; m_synced = 0; m_on_left = 0; e_data = '0; e_valid = 2'b00;
    end else if (!m_synced || !m_on_left) begin
      if (rl) launch = 1;
    end else if (rr) begin
      m_on_left = 0; e_data = m_cur_r; e_valid = 2'b01;
    end
    if (launch) begin
      m_synced = 1; m_on_left = 1; e_tick = 1; e_valid = 2'b10;
      if (mq.size() > 0) begin
        f = mq.pop_front();
        e_data  = vol(f[47:24], vol_shift);
        m_cur_r = vol(f[23:0], vol_shift);
      end else begin
        e_data = '0; m_cur_r = '0; e_unr = 1;
        if (e_cnt != 16'hFFFF) e_cnt++;
      end
    end
    if (underrun_clr) begin
      e_unr = 0; e_cnt = '0;
    end
    if (flush)     mq.delete();
    else if (e_ga) mq.push_back(src_a_data);
    else if (e_gb) mq.push_back(src_b_data);
  endtask

  // Inputs are driven just after a posedge; ready is checked mid-cycle,
  // registered outputs 1 time unit after the next posedge.
  task automatic cycle();
    #1;
    model_step();
    obs_a = src_a_ready;
    obs_b = src_b_ready;
    check_eq("src_a_ready", src_a_ready, e_ga);
    check_eq("src_b_ready", src_b_ready, e_gb);
    @(posedge sys_clk);
    #1;
    check_eq("pcm_data", pcm_data, e_data);
    check_eq("pcm_data_valid", pcm_data_valid, e_valid);
    check_eq("fifo_count", fifo_count, mq.size());
    check_eq("underrun", underrun, e_unr);
    check_eq("underrun_count", underrun_count, e_cnt);
    check_eq("frame_tick", frame_tick, e_tick);
  endtask

  task automatic do_reset();
    sys_reset_n = 0;
    cycle();
    sys_reset_n = 1;
  endtask

  task automatic slot(input logic [1:0] r);
    pcm_data_ready = r;
    cycle();
    pcm_data_ready = 2'b00;
    cycle();
  endtask

  int b_grants;

  initial begin
    n_tests = 0; n_fail = 0;
    sys_reset_n = 0; enable = 0; arb_mode = 0; vol_shift = '0; flush = 0;
    src_a_data = '0; src_a_valid = 0; src_b_data = '0; src_b_valid = 0;
    pcm_data_ready = 2'b00; underrun_clr = 0;
    do_reset();
    do_reset();
    check_eq("reset_valid", pcm_data_valid, 2'b00);
    check_eq("reset_count", fifo_count, 0);

    // Startup frame
    enable = 1; src_a_valid = 1; src_a_data = {24'h100000, 24'h0FFFFF};
    cycle();
    src_a_valid = 0; pcm_data_ready = 2'b10;
    cycle();
    check_eq("start_l_data", pcm_data, 24'h100000);
    check_eq("start_l_valid", pcm_data_valid, 2'b10);
    check_eq("start_tick", frame_tick, 1);
    pcm_data_ready = 2'b00;
    cycle();
    check_eq("start_tick_once", frame_tick, 0);
    pcm_data_ready = 2'b01;
    cycle();
    check_eq("start_r_data", pcm_data, 24'h0FFFFF);
    check_eq("start_r_valid", pcm_data_valid, 2'b01);
    pcm_data_ready = 2'b00;
    cycle();

    // Fixed priority with draining, then full
    do_reset();
    arb_mode = 0; src_a_valid = 1; src_b_valid = 1; b_grants = 0;
    for (int i = 0; i < 12; i++) begin
      src_a_data = {$urandom, $urandom}; src_b_data = {$urandom, $urandom};
      pcm_data_ready = (i % 4 == 0) ? 2'b10 : (i % 4 == 2) ? 2'b01 : 2'b00;
      cycle();
      if (obs_b) b_grants++;
    end
    check_eq("arb0_b_grants", b_grants, 0);
    pcm_data_ready = 2'b00;
    for (int i = 0; i < 5; i++) cycle();
    check_eq("full_count", fifo_count, 4);
    cycle();
    check_eq("full_ready", {obs_a, obs_b}, 2'b00);

    // Round-robin from reset: A,B,A,B
    enable = 0;
    do_reset();
    arb_mode = 1;
    for (int i = 0; i < 4; i++) begin
      src_a_data = {$urandom, $urandom}; src_b_data = {$urandom, $urandom};
      cycle();
      check_eq("rr_seq", {obs_a, obs_b}, (i % 2 == 0) ? 2'b10 : 2'b01);
    end
    src_a_valid = 0; src_b_valid = 0; arb_mode = 0;

    // Underrun
    do_reset();
    enable = 1;
    cycle();
    for (int k = 0; k < 3; k++) begin
      pcm_data_ready = 2'b10; cycle();
      check_eq("unr_l_data", pcm_data, 0);
      pcm_data_ready = 2'b00; cycle();
      pcm_data_ready = 2'b01; cycle();
      check_eq("unr_r_data", pcm_data, 0);
      pcm_data_ready = 2'b00; cycle();
    end
    check_eq("unr_flag", underrun, 1);
    check_eq("unr_count3", underrun_count, 3);
    underrun_clr = 1; pcm_data_ready = 2'b10;
    cycle();
    underrun_clr = 0; pcm_data_ready = 2'b00;
    check_eq("unr_clr_flag", underrun, 0);
    check_eq("unr_clr_count", underrun_count, 0);
    cycle();
    pcm_data_ready = 2'b01; cycle();
    pcm_data_ready = 2'b00;

    // Volume
    vol_shift = 4; src_a_valid = 1; src_a_data = {24'h800000, 24'h7FFFFF};
    cycle();
    src_a_valid = 0; pcm_data_ready = 2'b10;
    cycle();
    check_eq("vol4_l", pcm_data, 24'hF80000);
    pcm_data_ready = 2'b00; cycle();
    pcm_data_ready = 2'b01; cycle();
    check_eq("vol4_r", pcm_data, 24'h07FFFF);
    pcm_data_ready = 2'b00;
    vol_shift = 23; src_a_valid = 1; src_a_data = {24'h800000, 24'h000005};
    cycle();
    src_a_valid = 0; pcm_data_ready = 2'b11;   // both edges: left launch only
    cycle();
    check_eq("both_valid", pcm_data_valid, 2'b10);
    check_eq("vol23_l", pcm_data, 24'hFFFFFF);
    pcm_data_ready = 2'b00; cycle();
    pcm_data_ready = 2'b01; cycle();
    check_eq("vol23_r", pcm_data, 24'h000000);
    pcm_data_ready = 2'b00; vol_shift = 0;

    // Held left request: one pop only
    src_a_valid = 1; src_a_data = {$urandom, $urandom};
    cycle();
    src_a_data = {$urandom, $urandom};
    cycle();
    src_a_valid = 0; pcm_data_ready = 2'b10;
    for (int i = 0; i < 50; i++) cycle();
    check_eq("held_pop_once", fifo_count, 1);
    pcm_data_ready = 2'b00; cycle();
    pcm_data_ready = 2'b01; cycle();
    pcm_data_ready = 2'b00;

    // Flush during push
    src_a_valid = 1; flush = 1; src_a_data = {$urandom, $urandom};
    cycle();
    check_eq("flush_ready", obs_a, 0);
    check_eq("flush_count", fifo_count, 0);
    flush = 0;

    // Disable while on the right slot
    cycle();
    cycle();
    src_a_valid = 0; pcm_data_ready = 2'b10; cycle();
    pcm_data_ready = 2'b00; cycle();
    pcm_data_ready = 2'b01; cycle();
    check_eq("dis_pre_valid", pcm_data_valid, 2'b01);
    enable = 0; pcm_data_ready = 2'b00;
    cycle();
    check_eq("dis_valid", pcm_data_valid, 2'b00);
    check_eq("dis_data", pcm_data, 0);
    check_eq("dis_fifo_kept", fifo_count, 1);

    // Reset mid-frame
    enable = 1; cycle();
    pcm_data_ready = 2'b10; cycle();
    sys_reset_n = 0; pcm_data_ready = 2'b00;
    cycle();
    sys_reset_n = 1;
    check_eq("rst_valid", pcm_data_valid, 2'b00);
    check_eq("rst_count", fifo_count, 0);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      src_a_valid  = ($urandom % 3) != 0;
      src_b_valid  = ($urandom % 2) != 0;
      src_a_data   = {$urandom, $urandom};
      src_b_data   = {$urandom, $urandom};
      if ($urandom % 100 == 0) arb_mode = ~arb_mode;
      if ($urandom % 60 == 0)  vol_shift = 5'($urandom_range(0, 23));
      flush        = ($urandom % 40) == 0;
      underrun_clr = ($urandom % 30) == 0;
      if ($urandom % 80 == 0) enable = ~enable;
      if (!enable && ($urandom % 4 == 0)) enable = 1;
      sys_reset_n  = ($urandom % 500) != 0;
      pcm_data_ready = 2'($urandom);
      cycle();
    end
    sys_reset_n = 1; flush = 0; underrun_clr = 0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
